// File: rtl/upsert_ctrl_fsm.sv
// Upsert sequencer: lookup, wait with timeout, then update / insert / error, one write strobe.
// Optional victim-overwrite on a full-table miss when UPSERT_EVICT_EN is defined.
module upsert_ctrl_fsm #(
  parameter int NUM_ENTRIES = 16,
  parameter int LKP_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   hit_vld,
  input  logic                   hit,
  input  logic [NUM_ENTRIES-1:0] hit_idx,
  input  logic [NUM_ENTRIES-1:0] used,
  output logic                   busy,
  output logic                   lookup_req,
  output logic                   write_en,
  output logic                   select_out,
  output logic [NUM_ENTRIES-1:0] idx_out,
  output logic                   evict,
  output logic                   done,
  output logic [2:0]             err_code
);

  localparam int CNT_W = $clog2(LKP_TIMEOUT + 1);

  localparam logic [1:0] MODE_INS = 2'b01;
  localparam logic [1:0] MODE_UPD = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_FULL    = 3'd1;
  localparam logic [2:0] ERR_EXISTS  = 3'd2;
  localparam logic [2:0] ERR_MISSING = 3'd3;
  localparam logic [2:0] ERR_MODE    = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WAIT, S_ALLOC, S_WRITE, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_ENTRIES-1:0] used_q, used_d;
  logic [NUM_ENTRIES-1:0] idx_q, idx_d;
  logic                   sel_q, sel_d;
  logic [2:0]             err_q, err_d;

`ifdef UPSERT_EVICT_EN
  localparam int VW = $clog2(NUM_ENTRIES);
  logic [VW-1:0] vict_q, vict_d;
  logic          evict_q, evict_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      cnt_q  <= '0;
      used_q <= '0;
      idx_q  <= '0;
      sel_q  <= 1'b0;
      err_q  <= ERR_OK;
`ifdef UPSERT_EVICT_EN
      vict_q  <= '0;
      evict_q <= 1'b0;
`endif
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      used_q <= used_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
`ifdef UPSERT_EVICT_EN
      vict_q  <= vict_d;
      evict_q <= evict_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    err_d   = err_q;
`ifdef UPSERT_EVICT_EN
    vict_d  = vict_q;
    evict_d = evict_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          if (mode == MODE_BAD) begin
            state_d = S_DONE;
            err_d   = ERR_MODE;
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hit_vld) begin
          used_d = used;
          if (hit && mode_q != MODE_INS) begin
            state_d = S_WRITE;
            sel_d   = 1'b1;
            // Multi-hot hit: isolate the lowest set bit
            idx_d   = hit_idx & (~hit_idx + NUM_ENTRIES'(1));
          end else if (hit) begin
            state_d = S_DONE;
            err_d   = ERR_EXISTS;
          end else if (mode_q == MODE_UPD) begin
            state_d = S_DONE;
            err_d   = ERR_MISSING;
          end else if (!(&used)) begin
            state_d = S_ALLOC;
          end else begin
`ifdef UPSERT_EVICT_EN
            state_d = S_WRITE;
            sel_d   = 1'b0;
            idx_d   = NUM_ENTRIES'(1) << vict_q;
            evict_d = 1'b1;
            vict_d  = (vict_q == VW'(NUM_ENTRIES - 1)) ? '0 : vict_q + VW'(1);
`else
            state_d = S_DONE;
            err_d   = ERR_FULL;
`endif
          end
        end else begin
          // Abort in the WAIT cycle where the count reaches the limit
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(LKP_TIMEOUT)) begin
            state_d = S_DONE;
            err_d   = ERR_TIMEOUT;
          end
        end
      end
      S_ALLOC: begin
        idx_d   = ~used_q & (used_q + NUM_ENTRIES'(1));
        sel_d   = 1'b0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        err_d   = ERR_OK;
        state_d = S_DONE;
      end
      S_DONE: begin
        idx_d   = '0;
        sel_d   = 1'b0;
`ifdef UPSERT_EVICT_EN
        evict_d = 1'b0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    lookup_req = (state_q == S_LOOKUP);
    write_en   = (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    select_out = sel_q;
    idx_out    = idx_q;
    err_code   = err_q;
`ifdef UPSERT_EVICT_EN
    evict      = evict_q;
`else
    evict      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_upsert_ctrl_fsm.sv
// Directed bench for upsert_ctrl_fsm: update, insert, full table, error codes, timeout, reset abort.
module tb_upsert_ctrl_fsm;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst, start, hit_vld, hit;
  logic [1:0]   mode;
  logic [N-1:0] hit_idx, used;
  logic         busy, lookup_req, write_en, select_out, evict, done;
  logic [N-1:0] idx_out;
  logic [2:0]   err_code;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  upsert_ctrl_fsm #(.NUM_ENTRIES(N), .LKP_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .hit_vld(hit_vld), .hit(hit), .hit_idx(hit_idx), .used(used),
    .busy(busy), .lookup_req(lookup_req), .write_en(write_en),
    .select_out(select_out), .idx_out(idx_out), .evict(evict),
    .done(done), .err_code(err_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse sampled in cycle 0; returns in cycle 1
  task automatic launch(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_lkp(input logic v, input logic h, input logic [N-1:0] hi, input logic [N-1:0] u);
    hit_vld = v;
    hit     = h;
    hit_idx = hi;
    used    = u;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00;
    set_lkp(1'b0, 1'b0, '0, '0);
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", idx_out, 0);
    chk("rst_err", err_code, 0);
    rst = 1'b0;
    tick();

    // Upsert hit
    launch(2'b00);
    chk("t1_lookup", lookup_req, 1);
    chk("t1_busy", busy, 1);
    set_lkp(1'b1, 1'b1, 16'h0008, 16'h00FF);
    tick();
    chk("t1_c2_wen", write_en, 0);
    chk("t1_c2_lookup", lookup_req, 0);
    tick();
    chk("t1_wen", write_en, 1);
    chk("t1_sel", select_out, 1);
    chk("t1_idx", idx_out, 16'h0008);
    chk("t1_evict", evict, 0);
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_err", err_code, 0);
    chk("t1_done_idx", idx_out, 16'h0008);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_idx", idx_out, 0);
    chk("t1_idle_done", done, 0);

    // Update with multi-hot hit: lowest bit wins
    launch(2'b10);
    set_lkp(1'b1, 1'b1, 16'h0A00, 16'hFFFF);
    tick(); tick();
    chk("mh_wen", write_en, 1);
    chk("mh_idx", idx_out, 16'h0200);
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();
    chk("mh_done", done, 1);
    tick();

    // Insert with free slot
    launch(2'b01);
    set_lkp(1'b1, 1'b0, '0, 16'h00FF);
    tick();
    tick();
    chk("t2_alloc_wen", write_en, 0);
    chk("t2_alloc_idx", idx_out, 0);
    chk("t2_alloc_busy", busy, 1);
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();
    chk("t2_wen", write_en, 1);
    chk("t2_idx", idx_out, 16'h0100);
    chk("t2_sel", select_out, 0);
    tick();
    chk("t2_done", done, 1);
    chk("t2_err", err_code, 0);
    tick();

    // Full table miss
`ifdef UPSERT_EVICT_EN
    for (int k = 0; k < 3; k++) begin
      launch(2'b00);
      set_lkp(1'b1, 1'b0, '0, 16'hFFFF);
      tick(); tick();
      chk("t3_wen", write_en, 1);
      chk("t3_idx", idx_out, 32'(1) << k);
      chk("t3_evict", evict, 1);
      chk("t3_sel", select_out, 0);
      set_lkp(1'b0, 1'b0, '0, '0);
      tick();
      chk("t3_done", done, 1);
      chk("t3_err", err_code, 0);
      tick();
    end
`else
    launch(2'b00);
    set_lkp(1'b1, 1'b0, '0, 16'hFFFF);
    tick();
    chk("t3_c2_wen", write_en, 0);
    tick();
    chk("t3_done", done, 1);
    chk("t3_err", err_code, 1);
    chk("t3_wen", write_en, 0);
    chk("t3_evict", evict, 0);
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();
`endif

    // Insert-only on a hit -> exists
    launch(2'b01);
    set_lkp(1'b1, 1'b1, 16'h0004, 16'h000F);
    tick(); tick();
    chk("t4a_done", done, 1);
    chk("t4a_err", err_code, 2);
    chk("t4a_idx", idx_out, 0);
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();

    // Update-only miss -> missing; start held while busy must be ignored
    launch(2'b10);
    set_lkp(1'b1, 1'b0, '0, 16'h000F);
    tick();
    start = 1'b1;
    tick();
    chk("t4b_done", done, 1);
    chk("t4b_err", err_code, 3);
    start = 1'b0;
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();
    chk("t4b_idle_busy", busy, 0);
    chk("t4b_hold_err", err_code, 3);
    tick();
    chk("t4b_no_lookup", lookup_req, 0);

    // Reserved mode -> immediate bad-mode completion
    launch(2'b11);
    chk("t4c_done", done, 1);
    chk("t4c_err", err_code, 4);
    chk("t4c_lookup", lookup_req, 0);
    tick();
    chk("t4c_idle", busy, 0);
    chk("t4c_hold_err", err_code, 4);

    // Timeout: 15 WAIT cycles with no result
    launch(2'b00);
    for (int i = 0; i < 15; i++) tick();
    chk("t5_wait15_done", done, 0);
    chk("t5_wait15_busy", busy, 1);
    tick();
    chk("t5_done", done, 1);
    chk("t5_err", err_code, 5);
    tick();

    // Result arrives in the 15th WAIT cycle: normal completion
    launch(2'b00);
    for (int i = 0; i < 15; i++) tick();
    set_lkp(1'b1, 1'b1, 16'h0001, 16'h0001);
    tick();
    chk("t5b_wen", write_en, 1);
    chk("t5b_idx", idx_out, 16'h0001);
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();
    chk("t5b_done", done, 1);
    chk("t5b_err", err_code, 0);
    tick();

    // Reset during WAIT (after a timeout leaves err 5 visible)
    launch(2'b01);
    for (int i = 0; i < 16; i++) tick();
    tick();
    launch(2'b00);
    tick();
    chk("t6a_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("t6a_busy", busy, 0);
    chk("t6a_done", done, 0);
    chk("t6a_err", err_code, 0);
    rst = 1'b0;
    tick();
    chk("t6a_after_done", done, 0);

    // Reset during WRITE
    launch(2'b00);
    set_lkp(1'b1, 1'b1, 16'h0020, 16'h0020);
    tick(); tick();
    chk("t6b_pre_wen", write_en, 1);
    rst = 1'b1;
    tick();
    chk("t6b_wen", write_en, 0);
    chk("t6b_idx", idx_out, 0);
    chk("t6b_sel", select_out, 0);
    chk("t6b_done", done, 0);
    rst = 1'b0;
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();
    chk("t6b_after_done", done, 0);

    // New command accepted after reset
    launch(2'b00);
    chk("t6c_lookup", lookup_req, 1);
    set_lkp(1'b1, 1'b1, 16'h4000, 16'hFFFF);
    tick(); tick();
    chk("t6c_idx", idx_out, 16'h4000);
    set_lkp(1'b0, 1'b0, '0, '0);
    tick();
    chk("t6c_done", done, 1);
    chk("t6c_err", err_code, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
